cache_rd_arbiter: RTL and testbench
===================================

CACHE_RD_ARBITER -- requirements
Module: cache_rd_arbiter

Interface
REQ-001 clk  input  1  clock; all state updates on posedge.
REQ-002 resetn  input  1  reset, synchronous, active-low.
REQ-003 inst_req / inst_addr / inst_type  input  1/32/3  icache read request; type 3'b100 = 16-byte line, else one word.
REQ-004 inst_addr_ok  output  1  icache request accepted this cycle.
REQ-005 inst_data_ok / inst_rdata / inst_last  output  1/32/1  icache read beat, its data, and last-beat flag.
REQ-006 data_req / data_addr / data_type / data_addr_ok  in/in/in/out  1/32/3/1  dcache read request and accept, same encoding as icache.
REQ-007 data_data_ok / data_rdata / data_last  output  1/32/1  dcache read beat, its data, and last-beat flag.
REQ-008 wr_busy / wr_addr  input  1/32  write path holds an uncompleted write to wr_addr.
REQ-009 arid / araddr / arlen / arsize / arvalid / arready  out×5, in  4/32/8/3/1/1  AXI AR channel.
REQ-010 rid / rdata / rlast / rvalid / rready  in×4, out  4/32/1/1/1  AXI R channel.
REQ-011 err_rid  output  1  sticky flag: a beat arrived with an unknown rid.

Function
REQ-012 The arbiter SHALL use states IDLE and SEND; IDLE->SEND on any accept; SEND->IDLE on arvalid&arready.
REQ-013 In IDLE, grant SHALL go to one eligible requester; eligible = req asserted, no outstanding burst for that source, and no hazard.
REQ-014 Hazard: dcache read is ineligible while wr_busy and wr_addr[31:4]==data_addr[31:4].
REQ-015 addr_ok SHALL be combinational, asserted only for the granted source in IDLE; at most one addr_ok per cycle.
REQ-016 On accept, addr/type/source SHALL be latched and outstanding[source] set; arvalid=1 from next cycle until arready.
REQ-017 araddr, arid, arlen SHALL stay stable while arvalid=1 and arready=0.
REQ-018 arid SHALL be 4'd0 for icache, 4'd1 for dcache.
REQ-019 arlen SHALL be 8'd3 for type 3'b100, else 8'd0.
REQ-020 arsize SHALL be 3'b010, constant.
REQ-021 rready SHALL be constant 1.
REQ-022 A beat with rvalid and rid==0 SHALL drive inst_data_ok=1, inst_rdata=rdata, and inst_last=rlast.
REQ-023 A beat with rvalid and rid==1 SHALL drive the dcache outputs in the same way; non-selected outputs SHALL be 0.
REQ-024 outstanding[src] SHALL clear on rvalid&rlast with a matching rid; a new grant to that src is allowed the following cycle.
REQ-025 Same-cycle grant to a source and rlast for the other source SHALL both take effect.
REQ-026 rvalid with rid>1 SHALL be discarded and SHALL set err_rid.
REQ-027 Minimum latency: req in cycle N -> arvalid in cycle N+1.

Reset
REQ-028 While resetn=0, state SHALL be IDLE and outstanding SHALL be cleared.
REQ-029 While resetn=0, arvalid, all addr_ok, data_ok, and last outputs SHALL be 0, and err_rid SHALL be cleared.
REQ-030 A reset mid-burst SHALL abandon all tracking; beats arriving after reset are handled per REQ-022/023/026.

Configuration
REQ-031 With ARB_RR_EN defined, grant SHALL be round-robin: a last_grant bit favours the source not granted last; it resets to dcache-last, so icache wins the first tie.
REQ-032 Without ARB_RR_EN, dcache SHALL have fixed priority over icache.

Structure
REQ-033 A shared package SHALL hold the ID constants (ICACHE_ID=0, DCACHE_ID=1), TYPE_LINE=3'b100, and the state enum.
REQ-034 One sub-module, rd_grant_sel, SHALL compute eligibility and grant combinationally, including the ARB_RR_EN logic; sequencing and routing stay in the top module.

Verification
REQ-035 Single icache word read 0x1C000000 type 0, arready=1 -> arvalid next cycle with arid=0, arlen=0; rdata 0xDEAD with rlast -> inst_data_ok=1, inst_rdata=0xDEAD, inst_last=1.
REQ-036 Simultaneous icache and dcache line reads -> without macro, dcache granted first (arid=1, arlen=3); with ARB_RR_EN after reset, icache first; the second source is granted after the first handshake.
REQ-037 wr_busy=1, wr_addr=0x80001004, dcache read 0x8000100C -> data_addr_ok=0 until wr_busy falls; dcache read 0x80002000 is accepted immediately.
REQ-038 arready held 0 for 5 cycles -> araddr/arid/arlen constant, no new addr_ok; accept on cycle 6.
REQ-039 rvalid with rid=4'd5 -> no data_ok on either side and err_rid=1 until reset.
REQ-040 Reset asserted while outstanding[0] is set -> after reset, a new icache request is granted immediately.

Source files
------------

// File: rtl/cache_rd_arbiter_pkg.sv
// Shared constants and types for the cache read arbiter.
package cache_rd_arbiter_pkg;

   localparam logic [3:0]  ICACHE_ID = 4'd0;
   localparam logic [3:0]  DCACHE_ID = 4'd1;
   localparam logic [2:0]  TYPE_LINE = 3'b100;
   localparam logic [2:0]  SIZE_WORD = 3'b010;
   localparam logic [7:0]  LEN_LINE  = 8'd3;
   localparam logic [7:0]  LEN_WORD  = 8'd0;
   // Addresses in the same 16-byte line compare equal under this mask.
   localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF0;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } arb_state_e;

   // A line request is a 4-beat burst, anything else is a single word.
   function automatic logic [7:0] burst_len(input logic [2:0] req_type);
      return (req_type == TYPE_LINE) ? LEN_LINE : LEN_WORD;
   endfunction

endpackage

// File: rtl/cache_rd_arbiter_grant_sel.sv
// rd_grant_sel: eligibility and grant between icache and dcache reads.
// Build option ARB_RR_EN: round-robin on ties, otherwise dcache wins.
module rd_grant_sel
   import cache_rd_arbiter_pkg::*;
(
   input  logic        idle_i,
   input  logic        inst_req_i,
   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic        wr_busy_i,
   input  logic [31:0] wr_addr_i,
   input  logic [1:0]  outstanding_i,
`ifdef ARB_RR_EN
   input  logic        last_grant_i,
`endif
   output logic        grant_inst_o,
   output logic        grant_data_o
);

   logic hazard;
   logic elig_inst;
   logic elig_data;

   // A dcache read must not overtake a pending write to the same line.
   assign hazard    = wr_busy_i & (((wr_addr_i ^ data_addr_i) & LINE_MASK) == 32'd0);
   assign elig_inst = inst_req_i & ~outstanding_i[0];
   assign elig_data = data_req_i & ~outstanding_i[1] & ~hazard;

   // Pick at most one winner, only while the AR channel is free.
   always_comb begin
      grant_inst_o = 1'b0;
      grant_data_o = 1'b0;
      if (idle_i) begin
         if (elig_inst && elig_data) begin
`ifdef ARB_RR_EN
            // last_grant_i=1 means dcache won last time.
            if (last_grant_i) grant_inst_o = 1'b1;
            else              grant_data_o = 1'b1;
`else
            grant_data_o = 1'b1;
`endif
         end else begin
            grant_inst_o = elig_inst;
            grant_data_o = elig_data;
         end
      end
   end

endmodule

// File: rtl/cache_rd_arbiter.sv
// cache_rd_arbiter: shares one AXI read channel between icache and dcache.
// Build option ARB_RR_EN selects round-robin arbitration (see rd_grant_sel).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | AR channel free, one eligible requester may be accepted
//   SEND  | latched request presented on AR, waiting for arready
module cache_rd_arbiter
   import cache_rd_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req_i,
   input  logic [31:0] inst_addr_i,
   input  logic [2:0]  inst_type_i,
   output logic        inst_addr_ok_o,
   output logic        inst_data_ok_o,
   output logic [31:0] inst_rdata_o,
   output logic        inst_last_o,
   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic [2:0]  data_type_i,
   output logic        data_addr_ok_o,
   output logic        data_data_ok_o,
   output logic [31:0] data_rdata_o,
   output logic        data_last_o,
   input  logic        wr_busy_i,
   input  logic [31:0] wr_addr_i,
   output logic [3:0]  arid_o,
   output logic [31:0] araddr_o,
   output logic [7:0]  arlen_o,
   output logic [2:0]  arsize_o,
   output logic        arvalid_o,
   input  logic        arready_i,
   input  logic [3:0]  rid_i,
   input  logic [31:0] rdata_i,
   input  logic        rlast_i,
   input  logic        rvalid_i,
   output logic        rready_o,
   output logic        err_rid_o
);

   arb_state_e  state_q;
   logic [1:0]  outstanding_q;
   logic [1:0]  outstanding_d;
   logic [31:0] addr_q;
   logic [2:0]  type_q;
   logic        src_q;
   logic        err_rid_q;
`ifdef ARB_RR_EN
   logic        last_grant_q;
`endif

   logic idle;
   logic grant_inst;
   logic grant_data;
   logic accept;
   logic beat_inst;
   logic beat_data;
   logic beat_bad;

   // Outputs are forced quiet during reset even before the first edge clears state.
   assign idle = resetn & (state_q == IDLE);

   rd_grant_sel u_grant_sel (
      .idle_i        (idle),
      .inst_req_i    (inst_req_i),
      .data_req_i    (data_req_i),
      .data_addr_i   (data_addr_i),
      .wr_busy_i     (wr_busy_i),
      .wr_addr_i     (wr_addr_i),
      .outstanding_i (outstanding_q),
`ifdef ARB_RR_EN
      .last_grant_i  (last_grant_q),
`endif
      .grant_inst_o  (grant_inst),
      .grant_data_o  (grant_data)
   );

   assign accept         = grant_inst | grant_data;
   assign inst_addr_ok_o = grant_inst;
   assign data_addr_ok_o = grant_data;

   assign arvalid_o = resetn & (state_q == SEND);
   assign araddr_o  = addr_q;
   assign arid_o    = src_q ? DCACHE_ID : ICACHE_ID;
   assign arlen_o   = burst_len(type_q);
   assign arsize_o  = SIZE_WORD;
   assign rready_o  = 1'b1;

   assign beat_inst = resetn & rvalid_i & (rid_i == ICACHE_ID);
   assign beat_data = resetn & rvalid_i & (rid_i == DCACHE_ID);
   assign beat_bad  = rvalid_i & (rid_i > DCACHE_ID);

   assign inst_data_ok_o = beat_inst;
   assign inst_rdata_o   = beat_inst ? rdata_i : 32'd0;
   assign inst_last_o    = beat_inst & rlast_i;
   assign data_data_ok_o = beat_data;
   assign data_rdata_o   = beat_data ? rdata_i : 32'd0;
   assign data_last_o    = beat_data & rlast_i;
   assign err_rid_o      = resetn & err_rid_q;

   // AR sequencing: hold the request on the channel until the slave takes it.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE:    if (accept)    state_q <= SEND;
            SEND:    if (arready_i) state_q <= IDLE;
            default:                state_q <= IDLE;
         endcase
      end
   end

   // Capture the winning request; stays frozen while it waits on arready.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q <= grant_data ? data_addr_i : inst_addr_i;
         type_q <= grant_data ? data_type_i : inst_type_i;
         src_q  <= grant_data;
      end
   end

   // Burst tracking: a grant and the other source's rlast may land together.
   always_comb begin
      outstanding_d = outstanding_q;
      if (beat_inst && rlast_i) outstanding_d[0] = 1'b0;
      if (beat_data && rlast_i) outstanding_d[1] = 1'b0;
      if (grant_inst)           outstanding_d[0] = 1'b1;
      if (grant_data)           outstanding_d[1] = 1'b1;
   end

   // Register the burst tracking state.
   always_ff @(posedge clk) begin
      if (!resetn) outstanding_q <= 2'b00;
      else         outstanding_q <= outstanding_d;
   end

   // Sticky flag for beats whose rid belongs to neither cache.
   always_ff @(posedge clk) begin
      if (!resetn)       err_rid_q <= 1'b0;
      else if (beat_bad) err_rid_q <= 1'b1;
   end

`ifdef ARB_RR_EN
   // Remember who won last; starts as dcache so icache takes the first tie.
   always_ff @(posedge clk) begin
      if (!resetn)     last_grant_q <= 1'b1;
      else if (accept) last_grant_q <= grant_data;
   end
`endif

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Scoreboard bench for cache_rd_arbiter; follows ARB_RR_EN if defined.
module tb_cache_rd_arbiter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        inst_req_i = 1'b0, data_req_i = 1'b0, wr_busy_i = 1'b0;
   logic [31:0] inst_addr_i = '0, data_addr_i = '0, wr_addr_i = '0, rdata_i = '0;
   logic [2:0]  inst_type_i = '0, data_type_i = '0;
   logic        arready_i = 1'b0, rlast_i = 1'b0, rvalid_i = 1'b0;
   logic [3:0]  rid_i = '0;
   logic        inst_addr_ok_o, inst_data_ok_o, inst_last_o;
   logic        data_addr_ok_o, data_data_ok_o, data_last_o;
   logic [31:0] inst_rdata_o, data_rdata_o, araddr_o;
   logic [3:0]  arid_o;
   logic [7:0]  arlen_o;
   logic [2:0]  arsize_o;
   logic        arvalid_o, rready_o, err_rid_o;

   always #5 clk = ~clk;

   cache_rd_arbiter dut (
      .clk(clk), .resetn(resetn),
      .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_type_i(inst_type_i),
      .inst_addr_ok_o(inst_addr_ok_o), .inst_data_ok_o(inst_data_ok_o),
      .inst_rdata_o(inst_rdata_o), .inst_last_o(inst_last_o),
      .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_type_i(data_type_i),
      .data_addr_ok_o(data_addr_ok_o), .data_data_ok_o(data_data_ok_o),
      .data_rdata_o(data_rdata_o), .data_last_o(data_last_o),
      .wr_busy_i(wr_busy_i), .wr_addr_i(wr_addr_i),
      .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
      .arvalid_o(arvalid_o), .arready_i(arready_i),
      .rid_i(rid_i), .rdata_i(rdata_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
      .rready_o(rready_o), .err_rid_o(err_rid_o)
   );

   typedef struct {
      logic        rst_n, ireq, dreq, wb, arr, rv, rl;
      logic [31:0] iaddr, daddr, wa, rd;
      logic [2:0]  itype, dtype;
      logic [3:0]  rid;
   } stim_t;

   typedef struct {
      logic        iaok, daok, arv, err, iok, dok, il, dl;
      logic [31:0] ird, drd;
   } cyc_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  id;
      logic [7:0]  len;
   } ar_t;

   cyc_t cyc_q[$];
   ar_t  ar_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: one AR slot, a busy flag per cache, sticky error, tie-break memory.
   bit   m_pend;
   ar_t  m_ar;
   bit   m_out[2];
   bit   m_err;
   bit   m_lg;
   int   beats_left[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_err = 0; m_lg = 1;
      m_out[0] = 0; m_out[1] = 0;
      beats_left[0] = 0; beats_left[1] = 0;
      ar_q.delete();
   endtask

   function automatic stim_t base();
      stim_t s;
      s = '{default: 0};
      s.rst_n = 1'b1;
      s.arr   = 1'b1;
      return s;
   endfunction

   // One clock cycle: drive, predict, then advance the model past the edge.
   task automatic step(input stim_t s);
      bit   elig_i, elig_d, g_i, g_d, hz;
      cyc_t e;
      ar_t  a;
      resetn = s.rst_n; inst_req_i = s.ireq; inst_addr_i = s.iaddr; inst_type_i = s.itype;
      data_req_i = s.dreq; data_addr_i = s.daddr; data_type_i = s.dtype;
      wr_busy_i = s.wb; wr_addr_i = s.wa; arready_i = s.arr;
      rvalid_i = s.rv; rid_i = s.rid; rdata_i = s.rd; rlast_i = s.rl;

      hz     = s.wb && (s.wa[31:4] == s.daddr[31:4]);
      elig_i = s.ireq && !m_out[0];
      elig_d = s.dreq && !m_out[1] && !hz;
      g_i = 0; g_d = 0;
      if (s.rst_n && !m_pend) begin
         if (elig_i && elig_d) begin
`ifdef ARB_RR_EN
            if (m_lg) g_i = 1; else g_d = 1;
`else
            g_d = 1;
`endif
         end else begin
            g_i = elig_i; g_d = elig_d;
         end
      end
      e.iaok = g_i; e.daok = g_d;
      e.arv  = s.rst_n && m_pend;
      e.err  = s.rst_n && m_err;
      e.iok  = s.rst_n && s.rv && (s.rid == 4'd0);
      e.dok  = s.rst_n && s.rv && (s.rid == 4'd1);
      e.ird  = e.iok ? s.rd : 32'd0;
      e.drd  = e.dok ? s.rd : 32'd0;
      e.il   = e.iok && s.rl;
      e.dl   = e.dok && s.rl;
      cyc_q.push_back(e);
      if (g_i || g_d) begin
         a.addr = g_d ? s.daddr : s.iaddr;
         a.id   = g_d ? 4'd1 : 4'd0;
         a.len  = ((g_d ? s.dtype : s.itype) == 3'b100) ? 8'd3 : 8'd0;
         ar_q.push_back(a);
      end

      @(posedge clk); #1;

      if (!s.rst_n) begin
         model_reset();
      end else begin
         if (s.rv && s.rid < 4'd2) begin
            if (beats_left[int'(s.rid)] > 0) beats_left[int'(s.rid)]--;
            if (s.rl) m_out[int'(s.rid)] = 0;
         end
         if (s.rv && s.rid > 4'd1) m_err = 1;
         if (m_pend && s.arr) begin
            m_pend = 0;
            beats_left[int'(m_ar.id)] = int'(m_ar.len) + 1;
         end
         if (g_i || g_d) begin
            m_pend = 1; m_ar = a; m_out[g_d] = 1; m_lg = g_d;
         end
      end
   endtask

   // Act as the AXI slave until every accepted burst has been returned.
   task automatic drain();
      stim_t s;
      int    src;
      for (int k = 0; k < 20; k++) begin
         if (!m_pend && beats_left[0] == 0 && beats_left[1] == 0) break;
         s = base();
         src = (beats_left[1] > 0) ? 1 : 0;
         if (beats_left[src] > 0) begin
            s.rv = 1; s.rid = 4'(src); s.rd = $urandom; s.rl = (beats_left[src] == 1);
         end
         step(s);
      end
   endtask

   function automatic stim_t rnd_stim();
      stim_t s;
      int    r, src;
      s = base();
      s.rst_n = ($urandom_range(0, 149) != 0);
      s.ireq  = 1'($urandom_range(0, 1));
      s.iaddr = $urandom;
      s.itype = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom_range(0, 3));
      s.dreq  = 1'($urandom_range(0, 1));
      s.daddr = $urandom;
      s.dtype = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom_range(0, 3));
      s.wb    = ($urandom_range(0, 2) == 0);
      s.wa    = ($urandom_range(0, 1) == 1) ? {s.daddr[31:4], 4'($urandom_range(0, 15))} : $urandom;
      s.arr   = ($urandom_range(0, 3) != 0);
      s.rd    = $urandom;
      src = -1;
      if (beats_left[0] > 0 && beats_left[1] > 0) src = $urandom_range(0, 1);
      else if (beats_left[0] > 0) src = 0;
      else if (beats_left[1] > 0) src = 1;
      r = $urandom_range(0, 99);
      if (r < 2) begin
         s.rv = 1; s.rid = 4'($urandom_range(2, 15)); s.rl = 1'($urandom_range(0, 1));
      end else if (r < 60 && src >= 0) begin
         s.rv = 1; s.rid = 4'(src); s.rl = (beats_left[src] == 1);
      end
      return s;
   endfunction

   // Monitor: compare the DUT against whatever the stimulus side predicted.
   cyc_t me;
   always @(negedge clk) begin
      if (cyc_q.size() > 0) begin
         me = cyc_q.pop_front();
         chk("inst_addr_ok", 32'(inst_addr_ok_o), 32'(me.iaok));
         chk("data_addr_ok", 32'(data_addr_ok_o), 32'(me.daok));
         chk("arvalid",      32'(arvalid_o),      32'(me.arv));
         chk("err_rid",      32'(err_rid_o),      32'(me.err));
         chk("inst_data_ok", 32'(inst_data_ok_o), 32'(me.iok));
         chk("data_data_ok", 32'(data_data_ok_o), 32'(me.dok));
         chk("inst_rdata",   inst_rdata_o,        me.ird);
         chk("data_rdata",   data_rdata_o,        me.drd);
         chk("inst_last",    32'(inst_last_o),    32'(me.il));
         chk("data_last",    32'(data_last_o),    32'(me.dl));
         chk("arsize",       32'(arsize_o),       32'h2);
         chk("rready",       32'(rready_o),       32'h1);
         if (arvalid_o) begin
            if (ar_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL ar_payload: arvalid=1 with no accepted request at %0t", $time);
            end else begin
               chk("araddr", araddr_o,      ar_q[0].addr);
               chk("arid",   32'(arid_o),   32'(ar_q[0].id));
               chk("arlen",  32'(arlen_o),  32'(ar_q[0].len));
               if (arready_i) void'(ar_q.pop_front());
            end
         end
      end
   end

   initial begin
      stim_t s;
      model_reset();
      @(posedge clk); #1;

      // reset with requests pending: nothing may be accepted
      s = base(); s.rst_n = 0; s.ireq = 1; s.dreq = 1;
      step(s); step(s);

      // single icache word read returning 0xDEAD
      s = base(); s.ireq = 1; s.iaddr = 32'h1C00_0000; s.itype = 3'd0;
      step(s);
      s.ireq = 0; step(s);
      s.rv = 1; s.rid = 4'd0; s.rd = 32'h0000_DEAD; s.rl = 1; step(s);
      s = base(); step(s);

      // simultaneous line reads from both caches
      s = base(); s.ireq = 1; s.dreq = 1; s.itype = 3'b100; s.dtype = 3'b100;
      s.iaddr = 32'h1C00_0100; s.daddr = 32'h8000_0040;
      repeat (4) step(s);
      drain();

      // write hazard holds the dcache read; a different line goes straight through
      s = base(); s.wb = 1; s.wa = 32'h8000_1004; s.dreq = 1; s.daddr = 32'h8000_100C;
      repeat (3) step(s);
      s.wb = 0; step(s);
      s.dreq = 0; step(s);
      drain();
      s = base(); s.wb = 1; s.wa = 32'h8000_1004; s.dreq = 1; s.daddr = 32'h8000_2000;
      step(s);
      s.dreq = 0; step(s);
      drain();

      // arready low for five cycles with another request waiting
      s = base(); s.ireq = 1; s.iaddr = 32'h1C00_0200; s.itype = 3'b100; s.arr = 0;
      step(s);
      s.ireq = 0; s.dreq = 1; s.daddr = 32'h8000_0300;
      repeat (5) step(s);
      s.arr = 1; step(s);
      step(s);
      s.dreq = 0; step(s);
      drain();

      // unknown rid beat
      s = base(); s.rv = 1; s.rid = 4'd5; s.rd = 32'h1234_5678; s.rl = 1;
      step(s);
      s = base(); repeat (3) step(s);

      // reset while an icache burst is outstanding
      s = base(); s.ireq = 1; s.iaddr = 32'h1C00_0400; s.itype = 3'b100;
      step(s);
      s.ireq = 0; step(s);
      s.rst_n = 0; step(s);
      s = base(); s.ireq = 1; s.iaddr = 32'h1C00_0500; step(s);
      s.ireq = 0; step(s);
      drain();

      repeat (4000) step(rnd_stim());
      s = base(); step(s); step(s);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
